// File: rtl/riscv_m_ext_unit_pkg.sv
// Shared definitions for the RV32M execution unit: funct3 encodings,
// decode constants and the controller state encoding.
package m_definitions;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } func3;

    localparam logic [6:0] OPCODE_OP     = 7'h33;
    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } m_state_e;

endpackage

// File: rtl/riscv_m_ext_unit_divider.sv
// Unsigned 32-iteration engine on a 64-bit {hi, lo} shift register.
// Divide mode: restoring division, lo ends as quotient, hi as remainder.
// Multiply mode: shift-add, {hi, lo} ends as the 64-bit product.
// start_i loads operands; done_o marks the edge of the final iteration,
// after which hi_o/lo_o hold the result until the next start.
module riscv_m_divider (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        mul_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [31:0] hi_q, hi_d, lo_q, lo_d, op_b_q;
    logic [4:0]  cnt_q;
    logic        run_q, mul_q;
    logic [32:0] shifted, diff, sum;

    // one iteration of either the restoring divide or the shift-add multiply
    always_comb begin
        shifted = {hi_q, lo_q[31]};
        diff    = shifted - {1'b0, op_b_q};
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_b_q} : 33'd0);
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (mul_q) begin
            {hi_d, lo_d} = {sum, lo_q[31:1]};
        end else if (!diff[32]) begin
            {hi_d, lo_d} = {diff[31:0], lo_q[30:0], 1'b1};
        end else begin
            {hi_d, lo_d} = {shifted[31:0], lo_q[30:0], 1'b0};
        end
    end

    // operand load on start, then iterate with a down-counter to terminal count
    always_ff @(posedge clk) begin
        if (resetn) begin
            run_q  <= 1'b0;
            mul_q  <= 1'b0;
            cnt_q  <= 5'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            op_b_q <= 32'd0;
        end else if (start_i) begin
            run_q  <= 1'b1;
            mul_q  <= mul_i;
            cnt_q  <= 5'd31;
            hi_q   <= 32'd0;
            lo_q   <= a_i;
            op_b_q <= b_i;
        end else if (run_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) run_q <= 1'b0;
        end
    end

    assign done_o = run_q && (cnt_q == 5'd0);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/riscv_m_ext_unit.sv
// RV32M multiply/divide unit for the execute stage.
// Optional macro RISCV_M_MUL_SINGLE_CYCLE_EN selects a combinational
// multiplier; otherwise multiplies run on the shared iterative engine.
//
// state  | meaning
// S_IDLE | waiting for an M-extension request
// S_MUL  | iterative multiply in progress
// S_DIV  | iterative divide in progress
// S_DONE | result on rd, ready/wr high for this cycle
module riscv_m_ext_unit
    import m_definitions::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [31:0] instruction,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        wr,
    output logic [31:0] rd,
    output logic        busy,
    output logic        ready
);

    m_state_e    state_q, state_d;
    func3        op_w, op_q;
    logic        accept_w, is_div_w, sgn_a_w, sgn_b_w, neg_a_w, neg_b_w;
    logic        ovf_w, special_w, start_w, mul_mode_w, eng_done_w;
    logic [31:0] mag_a_w, mag_b_w, spec_res_w, eng_hi_w, eng_lo_w;
    logic        neg_q, neg_rem_q, special_q;
    logic [31:0] spec_res_q, rd_q, result_w, quo_w, rem_w;
    logic [63:0] prod_w;
    logic        unused_fields;

    assign unused_fields = ^{instruction[24:15], instruction[11:7]};

    assign op_w     = func3'(instruction[14:12]);
    assign accept_w = valid && (state_q == S_IDLE) &&
                      (instruction[6:0] == OPCODE_OP) &&
                      (instruction[31:25] == FUNCT7_MULDIV);
    assign is_div_w = instruction[14];
    assign sgn_a_w  = (op_w == MUL) || (op_w == MULH) || (op_w == MULHSU) ||
                      (op_w == DIV) || (op_w == REM);
    assign sgn_b_w  = (op_w == MUL) || (op_w == MULH) ||
                      (op_w == DIV) || (op_w == REM);
    assign neg_a_w  = sgn_a_w && rs1[31];
    assign neg_b_w  = sgn_b_w && rs2[31];
    assign mag_a_w  = neg_a_w ? (~rs1 + 32'd1) : rs1;
    assign mag_b_w  = neg_b_w ? (~rs2 + 32'd1) : rs2;

    // divide-by-zero and signed overflow are resolved at accept
    assign ovf_w      = sgn_a_w && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign special_w  = is_div_w && ((rs2 == 32'd0) || ovf_w);
    assign spec_res_w = (rs2 == 32'd0) ? (instruction[13] ? rs1 : 32'hFFFF_FFFF)
                                       : (instruction[13] ? 32'd0 : 32'h8000_0000);

`ifdef RISCV_M_MUL_SINGLE_CYCLE_EN
    logic [63:0] prod_q;
    logic [63:0] a_ext_w, b_ext_w;

    assign a_ext_w    = {{32{neg_a_w}}, rs1};
    assign b_ext_w    = {{32{sgn_b_w && rs2[31]}}, rs2};
    assign start_w    = accept_w && is_div_w && !special_w;
    assign mul_mode_w = 1'b0;

    // product captured at accept, consumed in the following DONE cycle
    always_ff @(posedge clk) begin
        if (resetn)        prod_q <= 64'd0;
        else if (accept_w) prod_q <= a_ext_w * b_ext_w;
    end

    assign prod_w = prod_q;
`else
    assign start_w    = accept_w && !special_w;
    assign mul_mode_w = !is_div_w;
    assign prod_w     = neg_q ? (~{eng_hi_w, eng_lo_w} + 64'd1) : {eng_hi_w, eng_lo_w};
`endif

    riscv_m_divider u_divider (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (start_w),
        .mul_i   (mul_mode_w),
        .a_i     (mag_a_w),
        .b_i     (mag_b_w),
        .done_o  (eng_done_w),
        .hi_o    (eng_hi_w),
        .lo_o    (eng_lo_w)
    );

    // latch operation and sign fix-ups at accept; inputs are free afterwards
    always_ff @(posedge clk) begin
        if (resetn) begin
            op_q       <= MUL;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= 32'd0;
        end else if (accept_w) begin
            op_q       <= op_w;
            neg_q      <= neg_a_w ^ neg_b_w;
            neg_rem_q  <= neg_a_w;
            special_q  <= special_w;
            spec_res_q <= spec_res_w;
        end
    end

    assign quo_w = neg_q     ? (~eng_lo_w + 32'd1) : eng_lo_w;
    assign rem_w = neg_rem_q ? (~eng_hi_w + 32'd1) : eng_hi_w;

    // final result selection, valid in DONE
    always_comb begin
        result_w = 32'd0;
        case (op_q)
            MUL:                 result_w = prod_w[31:0];
            MULH, MULHSU, MULHU: result_w = prod_w[63:32];
            DIV, DIVU:           result_w = quo_w;
            default:             result_w = rem_w;
        endcase
        if (special_q) result_w = spec_res_q;
    end

    // state register
    always_ff @(posedge clk) begin
        if (resetn) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_w) begin
                    if (is_div_w) state_d = special_w ? S_DONE : S_DIV;
`ifdef RISCV_M_MUL_SINGLE_CYCLE_EN
                    else          state_d = S_DONE;
`else
                    else          state_d = S_MUL;
`endif
                end
            end
            S_MUL, S_DIV: if (eng_done_w) state_d = S_DONE;
            default:      state_d = S_IDLE;
        endcase
    end

    // rd keeps the last completed result between operations
    always_ff @(posedge clk) begin
        if (resetn)                 rd_q <= 32'd0;
        else if (state_q == S_DONE) rd_q <= result_w;
    end

    assign ready = (state_q == S_DONE);
    assign wr    = ready;
    assign busy  = (state_q != S_IDLE);
    assign rd    = ready ? result_w : rd_q;

endmodule

// File: tb/tb_riscv_m_ext_unit.sv
module tb_riscv_m_ext_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        wr, busy, ready;
    logic [31:0] rd;

    int checks = 0;
    int errors = 0;

`ifdef RISCV_M_MUL_SINGLE_CYCLE_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    always #5 clk = ~clk;

    riscv_m_ext_unit dut (
        .clk         (clk),
        .resetn      (resetn),
        .valid       (valid),
        .instruction (instruction),
        .rs1         (rs1),
        .rs2         (rs2),
        .wr          (wr),
        .rd          (rd),
        .busy        (busy),
        .ready       (ready)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return int'(a) / int'(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return int'(a) % int'(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request; returns result seen in the ready cycle and latency in edges.
    // With poke set, valid is raised once mid-operation and once during DONE.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit poke, output logic [31:0] res, output int lat);
        bit busy_bad;
        busy_bad    = 1'b0;
        instruction = {7'h01, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'h33};
        rs1         = a;
        rs2         = b;
        valid       = 1'b1;
        @(posedge clk); #1;
        valid       = 1'b0;
        rs1         = $urandom;
        rs2         = $urandom;
        instruction = {7'h01, 10'($urandom), 3'($urandom), 5'($urandom), 7'h33};
        lat = 1;
        while (!ready && lat < 40) begin
            if (!busy) busy_bad = 1'b1;
            if (poke && lat == 5) begin
                valid       = 1'b1;
                instruction = {7'h01, 10'd0, 3'd0, 5'd1, 7'h33};
            end
            if (lat == 6) valid = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = rd;
        chk("busy_while_running", {31'd0, busy_bad}, 32'd0);
        chk("done_flags", {29'd0, wr, busy, ready}, 32'd7);
        if (poke) begin
            valid       = 1'b1;
            instruction = {7'h01, 10'd0, 3'd0, 5'd1, 7'h33};
        end
        @(posedge clk); #1;
        valid = 1'b0;
        chk("after_done_flags", {29'd0, wr, busy, ready}, 32'd0);
        chk("rd_hold", rd, res);
        if (poke) begin
            @(posedge clk); #1;
            chk("no_queued_op", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        int          lat;
        logic [2:0]  f3;
        logic [31:0] a, b;
        bit          saw_ready;

        vecs.push_back('{3'd0, 32'h1111FFFF, 32'h1111FFFF, 32'hDDDC0001, "mul_1111ffff"});
        vecs.push_back('{3'd3, 32'h1111FFFF, 32'h1111FFFF, 32'h01236543, "mulhu_1111ffff"});
        vecs.push_back('{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, "mul_m1_m1"});
        vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1_m1"});
        vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1_m1"});
        vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_m1_m1"});
        vecs.push_back('{3'd1, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulh_2_m1"});
        vecs.push_back('{3'd0, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, "mul_2_m1"});
        vecs.push_back('{3'd4, 32'hFFFFFFF3, 32'h00000005, 32'hFFFFFFFE, "div_m13_5"});
        vecs.push_back('{3'd6, 32'hFFFFFFF3, 32'h00000005, 32'hFFFFFFFD, "rem_m13_5"});
        vecs.push_back('{3'd6, 32'h00000005, 32'hFFFFFFF3, 32'h00000005, "rem_5_m13"});
        vecs.push_back('{3'd4, 32'h00000022, 32'h00000017, 32'h00000001, "div_34_23"});
        vecs.push_back('{3'd4, 32'hFFFFFFDE, 32'h00000017, 32'hFFFFFFFF, "div_m34_23"});
        vecs.push_back('{3'd4, 32'h00000022, 32'hFFFFFFE9, 32'hFFFFFFFF, "div_34_m23"});
        vecs.push_back('{3'd4, 32'hFFFFFFDE, 32'hFFFFFFE9, 32'h00000001, "div_m34_m23"});
        vecs.push_back('{3'd4, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, "div_by0"});
        vecs.push_back('{3'd5, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, "divu_by0"});
        vecs.push_back('{3'd6, 32'hFFFFFFF3, 32'h00000000, 32'hFFFFFFF3, "rem_by0"});
        vecs.push_back('{3'd7, 32'h0000000D, 32'h00000000, 32'h0000000D, "remu_by0"});
        vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"});
        vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf"});
        vecs.push_back('{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "divu_big"});
        vecs.push_back('{3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "remu_big"});

        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b0;
        chk("reset_flags", {29'd0, wr, busy, ready}, 32'd0);
        chk("reset_rd", rd, 32'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, 1'b0, res, lat);
            chk(vecs[i].name, res, vecs[i].exp);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'(exp_lat(vecs[i].f3, vecs[i].a, vecs[i].b)));
        end

        // non-M instructions must be ignored
        valid = 1'b1; rs1 = 32'd3; rs2 = 32'd4;
        instruction = {7'h00, 10'd0, 3'd0, 5'd1, 7'h33};
        @(posedge clk); #1;
        chk("ignore_funct7", {30'd0, busy, ready}, 32'd0);
        instruction = {7'h01, 10'd0, 3'd4, 5'd1, 7'h3B};
        @(posedge clk); #1;
        valid = 1'b0;
        chk("ignore_opcode", {30'd0, busy, ready}, 32'd0);

        // valid pulses while busy and during DONE are ignored
        do_op(3'd4, 32'd100, 32'd7, 1'b1, res, lat);
        chk("poke_div_result", res, 32'd14);
        chk("poke_div_lat", 32'(lat), 32'd33);

        for (int n = 0; n < 80; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            do_op(f3, a, b, 1'b0, res, lat);
            chk($sformatf("rand_f3_%0d_%h_%h", f3, a, b), res, model(f3, a, b));
            chk("rand_lat", 32'(lat), 32'(exp_lat(f3, a, b)));
        end

        // reset in the middle of a divide aborts it
        instruction = {7'h01, 10'd0, 3'd5, 5'd2, 7'h33};
        rs1 = 32'd1000; rs2 = 32'd9; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_div_busy", {30'd0, busy, ready}, 32'd2);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("abort_flags", {29'd0, wr, busy, ready}, 32'd0);
        chk("abort_rd", rd, 32'd0);
        resetn = 1'b0;
        saw_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ready || busy) saw_ready = 1'b1;
        end
        chk("abort_no_ready", {31'd0, saw_ready}, 32'd0);

        do_op(3'd6, 32'hFFFFFFF3, 32'd5, 1'b0, res, lat);
        chk("post_reset_rem", res, 32'hFFFFFFFD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
